// File: rtl/lstm_cell_mc.sv
// lstm_cell_mc: multi-channel LSTM cell with per-channel C/H state.
// A shared multiplier pair is stepped through the f, i, o, g gates, then the
// cell update and the hidden output, so one sample takes 6 cycles.
// Build option: define LSTM_SAT_EN to saturate out-of-range reductions
// instead of wrapping them. The overflow flag is set in both builds.
module lstm_cell_mc #(
  parameter int DW   = 8,
  parameter int FRAC = 6,
  parameter int NCH  = 4,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          w_we,
  input  logic [3:0]    w_addr,
  input  logic [DW-1:0] w_data,
  input  logic          ch_clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_ch,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] out_c,
  output logic [CW-1:0] out_ch,
  output logic          of,
  input  logic          of_clr
);

  localparam int SW = DW + 2;
  localparam logic signed [DW-1:0] ONE    = DW'(1 << FRAC);
  localparam logic signed [DW-1:0] NONE   = -ONE;
  localparam logic signed [DW:0]   ONE_W  = (DW+1)'(1 << FRAC);
  localparam logic signed [DW:0]   HALF_W = (DW+1)'(1 << (FRAC-1));

  typedef enum logic [2:0] {S_IDLE, S_GF, S_GI, S_GO, S_GG, S_CELL, S_HOUT} state_t;
  state_t state, state_next;

  logic signed [DW-1:0] wgt   [12];
  logic signed [DW-1:0] c_mem [NCH];
  logic signed [DW-1:0] h_mem [NCH];
  logic signed [DW-1:0] x_reg, hp_reg, cp_reg, f_reg, i_reg, o_reg, g_reg, c_new_reg;
  logic [CW-1:0]        ch_reg;
  logic                 ch_ok_reg;

  logic                 idle_en, accept, in_ch_ok;
  logic [1:0]           gsel;
  logic                 is_gate, ovf_now, red_ovf;
  logic signed [DW-1:0] ma_x, ma_y, mb_x, mb_y, bias;
  logic signed [2*DW-1:0] prod_a, prod_b;
  logic signed [SW-1:0] sh_a, sh_b, sum;
  logic signed [DW-1:0] red_val, q, act_sig, act_tanh, c_lim, h_new;
  logic signed [DW:0]   sig_sum;

  function automatic logic signed [DW-1:0] clamp1(input logic signed [DW-1:0] v);
    if (v > ONE) return ONE;
    if (v < NONE) return NONE;
    return v;
  endfunction

  // Handshake: accept only when idle, enabled and not clearing a channel
  always_comb begin
    idle_en  = cen & (state == S_IDLE);
    in_ready = idle_en & ~ch_clr;
    accept   = in_valid & in_ready;
    in_ch_ok = ({1'b0, in_ch} < (CW+1)'(NCH));
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state: one step per enabled edge once a sample is accepted
  always_comb begin
    state_next = state;
    if (cen) begin
      case (state)
        S_IDLE:  if (accept) state_next = S_GF;
        S_GF:    state_next = S_GI;
        S_GI:    state_next = S_GO;
        S_GO:    state_next = S_GG;
        S_GG:    state_next = S_CELL;
        S_CELL:  state_next = S_HOUT;
        S_HOUT:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Shared datapath: operand muxing, multiply, shift, sum, range reduction, activations
  always_comb begin
    gsel    = 2'd0;
    is_gate = 1'b0;
    case (state)
      S_GF:    begin gsel = 2'd0; is_gate = 1'b1; end
      S_GI:    begin gsel = 2'd1; is_gate = 1'b1; end
      S_GO:    begin gsel = 2'd2; is_gate = 1'b1; end
      S_GG:    begin gsel = 2'd3; is_gate = 1'b1; end
      default: ;
    endcase
    c_lim = clamp1(c_new_reg);
    bias  = is_gate ? wgt[{2'b10, gsel}] : '0;
    ma_x  = x_reg;
    ma_y  = wgt[{1'b0, gsel, 1'b0}];
    mb_x  = hp_reg;
    mb_y  = wgt[{1'b0, gsel, 1'b1}];
    if (state == S_CELL) begin
      ma_x = f_reg; ma_y = cp_reg; mb_x = i_reg; mb_y = g_reg;
    end else if (state == S_HOUT) begin
      ma_x = o_reg; ma_y = c_lim; mb_x = '0; mb_y = '0;
    end
    prod_a = (2*DW)'(ma_x) * (2*DW)'(ma_y);
    prod_b = (2*DW)'(mb_x) * (2*DW)'(mb_y);
    sh_a   = SW'(prod_a >>> FRAC);
    sh_b   = SW'(prod_b >>> FRAC);
    sum    = sh_a + sh_b + {{2{bias[DW-1]}}, bias};
    // Out of range when the top bits are not a sign extension of bit DW-1
    red_ovf = (sum[SW-1:DW-1] != {(SW-DW+1){sum[DW-1]}});
`ifdef LSTM_SAT_EN
    if (red_ovf) red_val = sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else         red_val = sum[DW-1:0];
`else
    red_val = sum[DW-1:0];
`endif
    // Hard sigmoid: floor(pre/4) + 0.5, clamped to [0, 1.0]
    q       = red_val >>> 2;
    sig_sum = {q[DW-1], q} + HALF_W;
    if (sig_sum[DW])          act_sig = '0;
    else if (sig_sum > ONE_W) act_sig = ONE;
    else                      act_sig = sig_sum[DW-1:0];
    act_tanh = clamp1(red_val);
    h_new    = sh_a[DW-1:0];
    ovf_now  = red_ovf & (is_gate | (state == S_CELL));
  end

  // Weight/bias file: writable only while idle; addresses 12-15 dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 12; k++) wgt[k] <= '0;
    end else if (idle_en && w_we && (w_addr < 4'd12)) begin
      wgt[w_addr] <= w_data;
    end
  end

  // Per-channel C/H: cleared by ch_clr while idle, written back at HOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        c_mem[k] <= '0;
        h_mem[k] <= '0;
      end
    end else if (cen) begin
      for (int k = 0; k < NCH; k++) begin
        if ((state == S_IDLE) && ch_clr && (in_ch == CW'(k))) begin
          c_mem[k] <= '0;
          h_mem[k] <= '0;
        end else if ((state == S_HOUT) && ch_ok_reg && (ch_reg == CW'(k))) begin
          c_mem[k] <= c_new_reg;
          h_mem[k] <= h_new;
        end
      end
    end
  end

  // Sample capture, gate results, output registers and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg <= '0; hp_reg <= '0; cp_reg <= '0; ch_reg <= '0; ch_ok_reg <= 1'b0;
      f_reg <= '0; i_reg <= '0; o_reg <= '0; g_reg <= '0; c_new_reg <= '0;
      out_valid <= 1'b0; out_data <= '0; out_c <= '0; out_ch <= '0; of <= 1'b0;
    end else if (cen) begin
      out_valid <= 1'b0;
      of        <= (of & ~of_clr) | ovf_now;
      case (state)
        S_IDLE: if (accept) begin
          x_reg     <= in_data;
          ch_reg    <= in_ch;
          ch_ok_reg <= in_ch_ok;
          hp_reg    <= in_ch_ok ? h_mem[in_ch] : '0;
          cp_reg    <= in_ch_ok ? c_mem[in_ch] : '0;
        end
        S_GF:   f_reg     <= act_sig;
        S_GI:   i_reg     <= act_sig;
        S_GO:   o_reg     <= act_sig;
        S_GG:   g_reg     <= act_tanh;
        S_CELL: c_new_reg <= red_val;
        S_HOUT: if (ch_ok_reg) begin
          out_valid <= 1'b1;
          out_data  <= h_new;
          out_c     <= c_new_reg;
          out_ch    <= ch_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
